// File: rtl/io_pkg.sv
// Shared handshake codes and transmit FSM states for the byte-serial HW/SW link.
// The io_module receive path uses the same codes.
package io_pkg;

    localparam int DATA_W_DEF = 128;

    // to_sw_sig codes (hardware -> software)
    localparam logic [1:0] SIG_IDLE  = 2'b00;
    localparam logic [1:0] SIG_VALID = 2'b01;
    localparam logic [1:0] SIG_DONE  = 2'b10;

    // to_hw_sig codes (software -> hardware)
    localparam logic [1:0] ACK_IDLE  = 2'b00;
    localparam logic [1:0] ACK_BYTE  = 2'b01;
    localparam logic [1:0] ACK_DONE  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        WAIT_LOW,
        DONE,
        DONE_LOW
    } tx_state_t;

endpackage

// File: rtl/aes_result_tx_if.sv
// Bundle between the AES result transmitter and its neighbours (aes_controller and software port).
// master = transmitter side, slave = environment / software side.
interface aes_result_tx_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] msg_de;
    logic              aes_ready;
    logic [1:0]        to_hw_sig;
    logic [1:0]        to_sw_sig;
    logic [7:0]        to_sw_port;
    logic              tx_busy;
    logic              tx_done;
    logic [3:0]        byte_idx;

    modport master (
        input  msg_de,
        input  aes_ready,
        input  to_hw_sig,
        output to_sw_sig,
        output to_sw_port,
        output tx_busy,
        output tx_done,
        output byte_idx
    );

    modport slave (
        output msg_de,
        output aes_ready,
        output to_hw_sig,
        input  to_sw_sig,
        input  to_sw_port,
        input  tx_busy,
        input  tx_done,
        input  byte_idx
    );
endinterface

// File: rtl/aes_result_tx.sv
// Streams the 128-bit AES result to software MSB byte first over a 2-bit request/ack handshake.
// First byte valid 2 cycles after aes_ready rise; each byte holds until software acks then releases.
module aes_result_tx
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    aes_result_tx_if.master bus
);

    localparam int         NUM_BYTES = DATA_W / 8;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_BYTES - 1);

    tx_state_t         state_q, state_d;
    logic              aes_ready_q, aes_ready_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_done_q, tx_done_d;
    logic [1:0]        to_sw_sig_q, to_sw_sig_d;
    logic [7:0]        to_sw_port_q, to_sw_port_d;

    logic rise;
    logic load;
    logic last_byte;
    logic advance;

    // tx_busy_q high while still in IDLE marks the cycle right after a load.
    assign rise      = bus.aes_ready & ~aes_ready_q;
    assign load      = (state_q == IDLE) & rise & ~tx_busy_q;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign advance   = (state_q == WAIT_LOW) & (bus.to_hw_sig == ACK_IDLE) & ~last_byte;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tx_busy_q) state_d = PRESENT;
            end
            PRESENT: begin
                if (bus.to_hw_sig == ACK_BYTE) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (bus.to_hw_sig == ACK_IDLE) state_d = last_byte ? DONE : PRESENT;
            end
            DONE: begin
                if (bus.to_hw_sig == ACK_DONE) state_d = DONE_LOW;
            end
            DONE_LOW: begin
                if (bus.to_hw_sig == ACK_IDLE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered outputs line up with state_q.
    always_comb begin
        aes_ready_d  = bus.aes_ready;
        sreg_d       = sreg_q;
        byte_idx_d   = byte_idx_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;
        to_sw_sig_d  = SIG_IDLE;
        to_sw_port_d = to_sw_port_q;

        if (load) begin
            sreg_d     = bus.msg_de;
            byte_idx_d = 4'd0;
            tx_busy_d  = 1'b1;
        end

        if (advance) begin
            sreg_d     = sreg_q << 8;
            byte_idx_d = byte_idx_q + 4'd1;
        end

        if ((state_q == DONE_LOW) && (bus.to_hw_sig == ACK_IDLE)) begin
            tx_done_d = 1'b1;
            tx_busy_d = 1'b0;
        end

        case (state_d)
            PRESENT: begin
                to_sw_sig_d  = SIG_VALID;
                to_sw_port_d = sreg_d[DATA_W-1 -: 8];
            end
            DONE:    to_sw_sig_d = SIG_DONE;
            default: to_sw_sig_d = SIG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sreg_q       <= '0;
            byte_idx_q   <= 4'd0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            to_sw_sig_q  <= SIG_IDLE;
            to_sw_port_q <= 8'h00;
        end else begin
            sreg_q       <= sreg_d;
            byte_idx_q   <= byte_idx_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
            to_sw_sig_q  <= to_sw_sig_d;
            to_sw_port_q <= to_sw_port_d;
        end
    end

    // Edge history keeps tracking through reset so a level held high across reset is not a new edge.
    always_ff @(posedge clk) begin
        aes_ready_q <= aes_ready_d;
    end

    assign bus.to_sw_sig  = to_sw_sig_q;
    assign bus.to_sw_port = to_sw_port_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.byte_idx   = byte_idx_q;

endmodule

// File: tb/tb_aes_result_tx.sv
// Directed bench for aes_result_tx: acts as aes_controller and as the software side of the link.
module tb_aes_result_tx;
    import io_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   passes;

    aes_result_tx_if #(.DATA_W(128)) bus ();

    aes_result_tx #(.DATA_W(128)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Bounded wait for a to_sw_sig code; an expired budget counts as a failed check.
    task automatic wait_sig(input string tag, input logic [1:0] code);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.to_sw_sig === code) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, {127'd0, found}, 128'd1);
    endtask

    task automatic xfer(input logic [127:0] msg, input int stall_at, input int bad_at,
                        input int retrig_at, input int abort_at);
        logic [7:0] exp_b;
        bus.msg_de    = msg;
        bus.aes_ready = 1'b1;
        step();
        chk("load_busy", {127'd0, bus.tx_busy}, 128'd1);
        chk("load_sig_idle", {126'd0, bus.to_sw_sig}, {126'd0, SIG_IDLE});
        bus.aes_ready = 1'b0;
        step();
        chk("first_valid_lat", {126'd0, bus.to_sw_sig}, {126'd0, SIG_VALID});

        for (int i = 0; i < 16; i++) begin
            exp_b = msg[127 - 8*i -: 8];
            wait_sig("wait_valid", SIG_VALID);
            chk("byte_port", {120'd0, bus.to_sw_port}, {120'd0, exp_b});
            chk("byte_idx", {124'd0, bus.byte_idx}, 128'(i));

            if (i == abort_at) begin
                reset_n = 1'b0;
                step();
                chk("abort_sig", {126'd0, bus.to_sw_sig}, 128'd0);
                chk("abort_busy", {127'd0, bus.tx_busy}, 128'd0);
                chk("abort_idx", {124'd0, bus.byte_idx}, 128'd0);
                chk("abort_port", {120'd0, bus.to_sw_port}, 128'd0);
                reset_n = 1'b1;
                step();
                chk("abort_no_done", {127'd0, bus.tx_done}, 128'd0);
                chk("abort_stays_idle", {126'd0, bus.to_sw_sig}, 128'd0);
                return;
            end

            if (i == stall_at) begin
                for (int c = 0; c < 50; c++) begin
                    step();
                    chk("stall_hold", {118'd0, bus.to_sw_sig, bus.to_sw_port},
                        {118'd0, SIG_VALID, exp_b});
                end
                chk("stall_idx", {124'd0, bus.byte_idx}, 128'(i));
            end

            if (i == retrig_at) begin
                bus.msg_de    = '1;
                bus.aes_ready = 1'b1;
                step();
                bus.aes_ready = 1'b0;
                step();
                chk("retrig_port", {120'd0, bus.to_sw_port}, {120'd0, exp_b});
                chk("retrig_sig", {126'd0, bus.to_sw_sig}, {126'd0, SIG_VALID});
                chk("retrig_idx", {124'd0, bus.byte_idx}, 128'(i));
            end

            if (i == bad_at) begin
                bus.to_hw_sig = 2'b11;
                repeat (3) step();
                chk("bad11_sig", {126'd0, bus.to_sw_sig}, {126'd0, SIG_VALID});
                bus.to_hw_sig = ACK_DONE;
                repeat (2) step();
                chk("bad10_present", {126'd0, bus.to_sw_sig}, {126'd0, SIG_VALID});
            end

            bus.to_hw_sig = ACK_BYTE;
            step();
            chk("ack_sig_low", {126'd0, bus.to_sw_sig}, {126'd0, SIG_IDLE});
            chk("ack_port_hold", {120'd0, bus.to_sw_port}, {120'd0, exp_b});

            if (i == bad_at) begin
                bus.to_hw_sig = ACK_DONE;
                repeat (3) step();
                chk("bad10_waitlow", {126'd0, bus.to_sw_sig}, {126'd0, SIG_IDLE});
                chk("bad10_idx", {124'd0, bus.byte_idx}, 128'(i));
            end
            bus.to_hw_sig = ACK_IDLE;
        end

        wait_sig("wait_done", SIG_DONE);
        chk("done_busy", {127'd0, bus.tx_busy}, 128'd1);
        chk("done_idx", {124'd0, bus.byte_idx}, 128'd15);
        chk("done_no_pulse", {127'd0, bus.tx_done}, 128'd0);
        bus.to_hw_sig = ACK_DONE;
        step();
        chk("donelow_sig", {126'd0, bus.to_sw_sig}, {126'd0, SIG_IDLE});
        bus.to_hw_sig = ACK_IDLE;
        step();
        chk("tx_done_pulse", {127'd0, bus.tx_done}, 128'd1);
        chk("tx_busy_clear", {127'd0, bus.tx_busy}, 128'd0);
        step();
        chk("tx_done_one_cycle", {127'd0, bus.tx_done}, 128'd0);
        chk("idle_sig", {126'd0, bus.to_sw_sig}, {126'd0, SIG_IDLE});
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        reset_n       = 1'b0;
        bus.aes_ready = 1'b1;
        bus.msg_de    = 128'h0;
        bus.to_hw_sig = ACK_IDLE;

        step();
        step();
        chk("rst_sig", {126'd0, bus.to_sw_sig}, 128'd0);
        chk("rst_port", {120'd0, bus.to_sw_port}, 128'd0);
        chk("rst_busy", {127'd0, bus.tx_busy}, 128'd0);
        chk("rst_done", {127'd0, bus.tx_done}, 128'd0);
        chk("rst_idx", {124'd0, bus.byte_idx}, 128'd0);

        reset_n = 1'b1;
        repeat (4) step();
        chk("post_rst_no_start_busy", {127'd0, bus.tx_busy}, 128'd0);
        chk("post_rst_no_start_sig", {126'd0, bus.to_sw_sig}, 128'd0);
        bus.aes_ready = 1'b0;
        step();

        xfer(128'h00112233_44556677_8899AABB_CCDDEEFF, -1, -1, -1, -1);
        xfer(128'h00112233_44556677_8899AABB_CCDDEEFF,  3,  9, -1, -1);
        xfer(128'h00112233_44556677_8899AABB_CCDDEEFF, -1, -1,  6, -1);
        xfer(128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, -1, -1, -1,  5);
        xfer(128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, -1, -1, -1, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
